// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one newd/done I2C master between NREQ requesters.
// It latches the winner's command, strobes the master and returns the result or a timeout abort.
module i2c_txn_arbiter #(
   parameter int NREQ      = 4,
   parameter int NEWD_HOLD = 24,
   parameter int TIMEOUT   = 8192,
   parameter int TW        = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_wr,
   input  logic [NREQ*7-1:0] req_addr,
   input  logic [NREQ*8-1:0] req_wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              m_newd,
   output logic              m_wr,
   output logic [6:0]        m_addr,
   output logic [7:0]        m_wdata,
   input  logic [7:0]        m_rdata,
   input  logic              m_done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = $clog2(NEWD_HOLD + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state, state_d;
   logic [PW-1:0] ptr, gidx, win;
   logic          any_req;
   logic [HW-1:0] hold_cnt;
   logic [TW-1:0] to_cnt;
   logic          done_q;
   logic          done_rise, hold_last, tmo;

   assign done_rise = m_done & ~done_q;
   assign hold_last = (hold_cnt == HW'(NEWD_HOLD - 1));
   assign tmo       = (to_cnt == TW'(TIMEOUT - 1));
   assign busy      = (state != IDLE);

   // First set request at or above ptr, wrapping past NREQ-1.
   always_comb begin
      int            s;
      logic [PW-1:0] cand;
      any_req = 1'b0;
      win     = ptr;
      for (int i = 0; i < NREQ; i++) begin
         s = int'(ptr) + i;
         if (s >= NREQ) s = s - NREQ;
         cand = PW'(s);
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            win     = cand;
         end
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (any_req) state_d = ISSUE;
         ISSUE:   if (hold_last) state_d = WAIT;
         WAIT:    if (done_rise || tmo) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         gidx      <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         m_newd    <= 1'b0;
         m_wr      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         hold_cnt  <= '0;
         to_cnt    <= '0;
         done_q    <= 1'b0;
      end else begin
         // Tracked in every state so a level left over from an earlier op never looks like an edge.
         done_q    <= m_done;
         rsp_valid <= '0;
         case (state)
            IDLE: if (any_req) begin
               gidx     <= win;
               gnt      <= NREQ'(1) << win;
               m_wr     <= req_wr[win];
               m_addr   <= req_addr[7*win +: 7];
               m_wdata  <= req_wdata[8*win +: 8];
               m_newd   <= 1'b1;
               hold_cnt <= '0;
            end
            ISSUE: begin
               hold_cnt <= hold_cnt + HW'(1);
               if (hold_last) begin
                  m_newd <= 1'b0;
                  to_cnt <= '0;
               end
            end
            WAIT: begin
               to_cnt <= to_cnt + TW'(1);
               if (done_rise) begin
                  rsp_valid <= gnt;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= m_wr ? 8'h00 : m_rdata;
               end else if (tmo) begin
                  rsp_valid <= gnt;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= 8'h00;
               end
            end
            RESP: begin
               gnt <= '0;
               ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Shares one I2C master between NREQ independent requesters. The shared master uses the newd/done handshake. The block arbitrates round-robin and latches the winner's command. It drives a timed newd pulse to the master, waits for a rising edge on done, and returns rdata and completion status to the granted requester. It sits between the system-side clients and the master instance in the I2C subsystem. A timeout watchdog prevents a hung bus from starving the other requesters.

Parameters:
NREQ, 4, number of requesters (2..8)
NEWD_HOLD, 24, clk cycles m_newd is held high; must exceed one master bit-clock period (22 clk)
TIMEOUT, 8192, max clk cycles in WAIT before abort
TW, 14, timeout counter width; 2^TW must exceed TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester request level; held until the matching rsp_valid bit
req_wr  in  NREQ  per-requester direction, 1=write, 0=read
req_addr  in  NREQ*7  7-bit device address per requester; requester k uses bits [7k+6:7k]
req_wdata  in  NREQ*8  write byte per requester; requester k uses bits [8k+7:8k]
gnt  out  NREQ  one-hot grant, high from ISSUE through RESP
rsp_valid  out  NREQ  one-cycle completion pulse to the granted requester
rsp_rdata  out  8  read byte, valid with rsp_valid (0 for writes)
rsp_err  out  1  qualifies rsp_valid: 1 means timeout abort
busy  out  1  high whenever state != IDLE
m_newd  out  1  start strobe to the master
m_wr  out  1  latched direction
m_addr  out  7  latched address
m_wdata  out  8  latched write byte
m_rdata  in  8  master read data
m_done  in  1  master completion level (stays high at least one bit-clock)

Behaviour:
- Reset: every output is 0. State=IDLE. Round-robin pointer ptr=0. Counters=0. m_done edge register=0. The reset takes effect immediately in any state, including WAIT. The master is reset by the same rst.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, choose the first set bit searching from ptr upward, with wrap at NREQ-1 to 0.
  - Latch req_wr, req_addr and req_wdata of the winner into m_wr, m_addr and m_wdata.
  - Set gnt one-hot and go to ISSUE on the next edge.
  - No req set: remain in IDLE with all outputs held.
- ISSUE:
  - m_newd=1 for exactly NEWD_HOLD cycles, counted by hold_cnt.
  - Then m_newd=0 and go to WAIT.
  - Clear the timeout counter on entry to WAIT.
- WAIT:
  - done_q <= m_done every cycle. A rising edge (m_done & ~done_q) completes the transaction: capture m_rdata if m_wr=0, else 0. Go to RESP with rsp_err=0.
  - Timeout counter increments every cycle. When it reaches TIMEOUT, go to RESP with rsp_err=1 and rsp_rdata=0.
  - Simultaneous done edge and timeout in the same cycle: the done edge wins, rsp_err=0.
- RESP:
  - One cycle only: rsp_valid[granted]=1 and rsp_err as set in WAIT.
  - Next edge: gnt=0, ptr=granted+1 mod NREQ, return to IDLE.
  - Minimum gap between two transactions is therefore one IDLE cycle.
- A rising edge of m_done seen while in IDLE or ISSUE is ignored. done_q still tracks m_done, so a stale level is never counted as a completion.
- m_wr, m_addr and m_wdata stay stable from ISSUE through RESP. They change only at the next grant.
- Requester-side changes after grant are ignored, including deasserting req or changing req_addr. The transaction always runs to RESP.
- gnt and rsp_valid are always one-hot or zero. rsp_valid is only ever set on the bit that gnt also has set.
- rsp_rdata and rsp_err keep their values after RESP until the next RESP.

Test Plan:
1. req=0001, wr=1, addr=0x2A, wdata=0x5C:
   - m_newd high exactly 24 cycles.
   - m_addr=0x2A, m_wdata=0x5C.
   - On the m_done rising edge: rsp_valid=0001, rsp_err=0, rsp_rdata=0x00, gnt back to 0.
2. Write 0xA5 to addr 0x11 through requester 1, then a read of 0x11 by requester 2 → rsp_valid=0100, rsp_rdata=0xA5, rsp_err=0.
3. req=0101 held continuously with ptr=0 → grant order 0001, 0100, 0001, 0100. Each grant is preceded by exactly one IDLE cycle.
4. req=1111 for 8 transactions → each requester is granted exactly twice, in order 0,1,2,3,0,1,2,3.
5. Master done forced to 0 (slave ack stuck low):
   - WAIT aborts after 8192 cycles with rsp_valid=1 on the granted bit, rsp_err=1, rsp_rdata=0.
   - The next requester is then granted normally.
6. rst asserted mid-WAIT (also mid-ISSUE with m_newd=1):
   - All outputs are 0 asynchronously.
   - After release, ptr=0 and the first request is serviced normally with no phantom rsp_valid.
